// File: rtl/battle_sequencer.sv
// Battle phase sequencer: drives the shared phase bus and tracks player/enemy HP,
// the enemy pattern turn index and the post-hit invulnerability window.
module battle_sequencer #(
    parameter int PLAYER_HP_MAX = 20,
    parameter int ENEMY_HP_MAX  = 30,
    parameter int HIT_DAMAGE    = 2,
    parameter int PLAYER_ATK    = 5,
    parameter int IFRAME_CYCLES = 32500000,
    parameter int NUM_TURNS     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_in,
    input  logic       menu_done_in,
    input  logic       attack_done_in,
    input  logic       attack_hit_in,
    input  logic       enemy_busy_in,
    input  logic       enemy_finished_in,
    input  logic       damage_in,
    output logic [3:0] state_out,
    output logic [3:0] turn_out,
    output logic [7:0] player_hp_out,
    output logic [7:0] enemy_hp_out,
    output logic       invuln_out,
    output logic       game_over_out,
    output logic       victory_out
);

    // state      | meaning
    // S_IDLE     | waiting for start_in after reset
    // S_MENU     | player choosing FIGHT
    // S_ATTACK   | player attack minigame running
    // S_ENEMY    | enemy pattern running, damage accepted
    // S_GAME_OVER| player HP exhausted
    // S_VICTORY  | enemy HP exhausted
    typedef enum logic [3:0] {
        S_IDLE      = 4'b0000,
        S_MENU      = 4'b0001,
        S_ATTACK    = 4'b0010,
        S_ENEMY     = 4'b1000,
        S_GAME_OVER = 4'b1110,
        S_VICTORY   = 4'b1111
    } state_t;

    localparam int CNT_W = (IFRAME_CYCLES > 1) ? $clog2(IFRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] IFRAME_LOAD = CNT_W'(IFRAME_CYCLES - 1);
    localparam logic [7:0] P_HP_MAX  = 8'(PLAYER_HP_MAX);
    localparam logic [7:0] E_HP_MAX  = 8'(ENEMY_HP_MAX);
    localparam logic [7:0] DMG       = 8'(HIT_DAMAGE);
    localparam logic [7:0] ATK       = 8'(PLAYER_ATK);
    localparam logic [3:0] LAST_TURN = 4'(NUM_TURNS - 1);

    state_t           state;
    logic [CNT_W-1:0] iframe_cnt;
    logic             hit_accept;
    logic [7:0]       player_hp_hit;
    logic [7:0]       enemy_hp_atk;
    logic [3:0]       turn_next;

    // Busy is informational only; the sequencer never retries an enemy phase.
    logic unused_busy;
    assign unused_busy = enemy_busy_in;

    always_comb begin
        hit_accept    = 1'b0;
        player_hp_hit = 8'd0;
        enemy_hp_atk  = 8'd0;
        turn_next     = 4'd0;
        hit_accept    = damage_in && (state == S_ENEMY) && !invuln_out;
        if (player_hp_out > DMG)
            player_hp_hit = player_hp_out - DMG;
        if (enemy_hp_out > ATK)
            enemy_hp_atk = enemy_hp_out - ATK;
        if (turn_out != LAST_TURN)
            turn_next = turn_out + 4'd1;
    end

    assign state_out = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            turn_out      <= 4'd0;
            player_hp_out <= P_HP_MAX;
            enemy_hp_out  <= E_HP_MAX;
            invuln_out    <= 1'b0;
            iframe_cnt    <= '0;
            game_over_out <= 1'b0;
            victory_out   <= 1'b0;
        end else begin
            game_over_out <= 1'b0;
            victory_out   <= 1'b0;

            if (invuln_out) begin
                if (iframe_cnt == '0)
                    invuln_out <= 1'b0;
                else
                    iframe_cnt <= iframe_cnt - 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_in)
                        state <= S_MENU;
                end
                S_MENU: begin
                    if (menu_done_in)
                        state <= S_ATTACK;
                end
                S_ATTACK: begin
                    if (attack_done_in) begin
                        if (attack_hit_in)
                            enemy_hp_out <= enemy_hp_atk;
                        if (attack_hit_in && enemy_hp_atk == 8'd0) begin
                            state       <= S_VICTORY;
                            victory_out <= 1'b1;
                        end else begin
                            state <= S_ENEMY;
                        end
                    end
                end
                S_ENEMY: begin
                    // Damage wins over a coincident finished pulse.
                    if (hit_accept) begin
                        player_hp_out <= player_hp_hit;
                        iframe_cnt    <= IFRAME_LOAD;
                        invuln_out    <= 1'b1;
                    end
                    if (hit_accept && player_hp_hit == 8'd0) begin
                        state         <= S_GAME_OVER;
                        game_over_out <= 1'b1;
                    end else if (enemy_finished_in) begin
                        turn_out <= turn_next;
                        state    <= S_MENU;
                    end
                end
                S_GAME_OVER, S_VICTORY: begin
                    if (start_in) begin
                        player_hp_out <= P_HP_MAX;
                        enemy_hp_out  <= E_HP_MAX;
                        turn_out      <= 4'd0;
                        iframe_cnt    <= '0;
                        invuln_out    <= 1'b0;
                        state         <= S_MENU;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
